// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle for the two alu_arbiter ports.
interface alu_arbiter_if #(parameter int W = 16);
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] req0_a, req0_b, rsp0_data;
  logic [W-1:0] req1_a, req1_b, rsp1_data;
  modport master (
    output req0_valid, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one op in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int W       = 16,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_out,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
  logic [1:0]   state;
  logic [3:0]   cnt;
  logic         owner, last, g1, idle;
  logic [W-1:0] op_a, op_b, res;
`ifdef ALU_ARB_RR_EN
  assign g1 = bus.req1_valid && (!bus.req0_valid || !last);
`else
  logic unused_last;
  assign unused_last = last;
  assign g1 = bus.req1_valid && !bus.req0_valid;
`endif
  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign idle           = rst_n && state == IDLE;
  assign bus.req0_ready = idle && bus.req0_valid && !g1;
  assign bus.req1_ready = idle && g1;
  assign bus.rsp0_valid = state == RESP && !owner;
  assign bus.rsp1_valid = state == RESP && owner;
  assign bus.rsp0_data  = res;
  assign bus.rsp1_data  = res;
  assign alu_a          = op_a;
  assign alu_b          = op_b;
  assign busy           = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
    end else
      case (state)
        IDLE: if (bus.req0_valid || bus.req1_valid) begin
          op_a  <= g1 ? bus.req1_a : bus.req0_a;
          op_b  <= g1 ? bus.req1_b : bus.req0_b;
          owner <= g1;
          cnt   <= LAT_M1;
          state <= EXEC;
        end
        EXEC: if (cnt != '0) cnt <= cnt - 4'd1;
        else begin
          res   <= alu_out;
          state <= RESP;
        end
        RESP: if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
